// File: rtl/ibex_branch_resolve.sv
// Prediction queue and resolver for the fetch-stage static branch predictor.
// Compares each retired instruction against its recorded prediction and issues a registered redirect.
module ibex_branch_resolve #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_valid_i,
  output logic                push_ready_o,
  input  logic [31:0]         push_pc_i,
  input  logic                push_compressed_i,
  input  logic                push_taken_i,
  input  logic [31:0]         push_target_i,
  input  logic                resolve_valid_i,
  input  logic                resolve_is_cf_i,
  input  logic                resolve_taken_i,
  input  logic [31:0]         resolve_target_i,
  input  logic                flush_i,
  output logic                mispredict_o,
  output logic [31:0]         redirect_pc_o,
  output logic                underflow_o,
  output logic [CntWidth-1:0] branch_cnt_o,
  output logic [CntWidth-1:0] mispredict_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        compressed;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  pred_t               mem_q [Depth];
  pred_t               mem_d [Depth];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic                mispredict_q, mispredict_d;
  logic [31:0]         redirect_q, redirect_d;
  logic                underflow_q, underflow_d;
  logic [CntWidth-1:0] branch_cnt_q, branch_cnt_d;
  logic [CntWidth-1:0] mispred_cnt_q, mispred_cnt_d;

  logic                full, empty, do_push, do_pop, mp;
  logic [31:0]         seq_pc, redir;
  pred_t               head;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push_ready_o = ~full;

  assign head    = mem_q[rptr_q[AW-1:0]];
  assign seq_pc  = head.pc + (head.compressed ? 32'd2 : 32'd4);
  assign do_pop  = resolve_valid_i & ~empty;

  // Prediction check for the oldest entry.
  always_comb begin
    mp    = 1'b0;
    redir = seq_pc;
    if (!resolve_is_cf_i) begin
      mp = head.taken;
    end else if (!resolve_taken_i) begin
      mp = head.taken;
    end else begin
      redir = resolve_target_i;
      mp    = ~head.taken | (head.target != resolve_target_i);
    end
    mp = mp & do_pop;
  end

  // A redirect or external flush discards every younger prediction, including one arriving now.
  assign do_push = push_valid_i & ~full & ~mp & ~flush_i;

  always_comb begin
    mem_d         = mem_q;
    rptr_d        = rptr_q + PW'(do_pop);
    wptr_d        = wptr_q + PW'(do_push);
    mispredict_d  = mp;
    redirect_d    = mp ? redir : redirect_q;
    underflow_d   = underflow_q | (resolve_valid_i & empty);
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = '{pc: push_pc_i, compressed: push_compressed_i,
                                taken: push_taken_i, target: push_target_i};
    end
    if (mp || flush_i) begin
      wptr_d = rptr_d;
    end
    if (do_pop && resolve_is_cf_i && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CntWidth'(1);
    end
    if (mp && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      mispredict_q  <= 1'b0;
      redirect_q    <= '0;
      underflow_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mispredict_q  <= mispredict_d;
      redirect_q    <= redirect_d;
      underflow_q   <= underflow_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredict_o     = mispredict_q;
  assign redirect_pc_o    = redirect_q;
  assign underflow_o      = underflow_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// Directed bench for ibex_branch_resolve: a behavioural queue model feeds a scoreboard
// of expected redirect outcomes, compared one cycle after each resolve.
module tb_ibex_branch_resolve;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_valid = 1'b0, push_ready, push_c = 1'b0, push_t = 1'b0;
  logic [31:0]   push_pc = '0, push_tgt = '0;
  logic          res_valid = 1'b0, res_cf = 1'b0, res_t = 1'b0, flush = 1'b0;
  logic [31:0]   res_tgt = '0;
  logic          mispredict, underflow;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  ibex_branch_resolve #(.Depth(4), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_pc_i(push_pc),
    .push_compressed_i(push_c), .push_taken_i(push_t), .push_target_i(push_tgt),
    .resolve_valid_i(res_valid), .resolve_is_cf_i(res_cf), .resolve_taken_i(res_t),
    .resolve_target_i(res_tgt), .flush_i(flush),
    .mispredict_o(mispredict), .redirect_pc_o(redirect_pc), .underflow_o(underflow),
    .branch_cnt_o(branch_cnt), .mispredict_cnt_o(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        c;
    logic        t;
    logic [31:0] tgt;
  } pred_s;

  typedef struct {
    logic        mp;
    logic [31:0] redir;
  } exp_s;

  pred_s mq[$];
  exp_s  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    m_bcnt = 0, m_mcnt = 0;
  logic  m_uf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: model the expected outcome, clock, then compare against the scoreboard.
  task automatic cycle();
    pred_s e;
    exp_s  x;
    logic  exp_ready, pushed, popped;
    exp_ready = (mq.size() < 4);
    chk("push_ready", 32'(push_ready), 32'(exp_ready));
    pushed  = push_valid && exp_ready;
    popped  = res_valid && (mq.size() != 0);
    x.mp    = 1'b0;
    x.redir = '0;
    if (res_valid && mq.size() == 0) m_uf = 1'b1;
    if (popped) begin
      e = mq.pop_front();
      if (res_cf) m_bcnt++;
      if (e.t && !(res_cf && res_t)) begin
        x.mp = 1'b1; x.redir = e.pc + (e.c ? 32'd2 : 32'd4);
      end else if (res_cf && res_t && (!e.t || e.tgt != res_tgt)) begin
        x.mp = 1'b1; x.redir = res_tgt;
      end
      if (x.mp) m_mcnt++;
    end
    if (x.mp || flush) mq.delete();
    else if (pushed) mq.push_back('{pc: push_pc, c: push_c, t: push_t, tgt: push_tgt});
    sb.push_back(x);
    @(posedge clk);
    #1;
    push_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    x = sb.pop_front();
    chk("mispredict", 32'(mispredict), 32'(x.mp));
    if (x.mp) chk("redirect_pc", redirect_pc, x.redir);
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("branch_cnt", 32'(branch_cnt), 32'((m_bcnt > 15) ? 15 : m_bcnt));
    chk("mispredict_cnt", 32'(mispred_cnt), 32'((m_mcnt > 15) ? 15 : m_mcnt));
  endtask

  task automatic set_push(input logic [31:0] pc, input logic c, input logic t, input logic [31:0] tgt);
    push_valid = 1'b1; push_pc = pc; push_c = c; push_t = t; push_tgt = tgt;
  endtask

  task automatic set_res(input logic cf, input logic t, input logic [31:0] tgt);
    res_valid = 1'b1; res_cf = cf; res_t = t; res_tgt = tgt;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", 32'(push_ready), 32'd1);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_bcnt", 32'(branch_cnt), 32'd0);
    chk("rst_mcnt", 32'(mispred_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill and drain, including a push attempt while full
    for (int i = 0; i < 4; i++) begin
      set_push(32'h100 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      cycle();
    end
    set_push(32'h999, 1'b0, 1'b1, 32'h0);
    set_res(1'b0, 1'b0, 32'h0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      set_res(1'b0, 1'b0, 32'h0);
      cycle();
    end
    cycle();

    // Backward branch predicted taken, actually not taken
    set_push(32'h200, 1'b0, 1'b1, 32'h1F0); cycle();
    set_res(1'b1, 1'b0, 32'h0); cycle();
    cycle();

    // Forward branch predicted not taken, actually taken, with younger entries and a dropped push
    set_push(32'h300, 1'b1, 1'b0, 32'h0); cycle();
    set_push(32'h302, 1'b0, 1'b0, 32'h0); cycle();
    set_push(32'h306, 1'b0, 1'b1, 32'h500); cycle();
    set_res(1'b1, 1'b1, 32'h340);
    set_push(32'h30A, 1'b0, 1'b1, 32'h600);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_push(32'h340 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      set_res(1'b0, 1'b0, 32'h0);
      cycle();
    end

    // External flush with a push, then resolve on an empty queue
    for (int i = 0; i < 3; i++) begin
      set_push(32'h400 + 32'(4 * i), 1'b0, 1'b1, 32'h800);
      cycle();
    end
    flush = 1'b1;
    set_push(32'h40C, 1'b0, 1'b1, 32'h800);
    cycle();
    cycle();
    set_res(1'b0, 1'b0, 32'h0); cycle();

    // Flush together with a mispredicting resolve still redirects
    set_push(32'h480, 1'b0, 1'b1, 32'h900); cycle();
    set_push(32'h484, 1'b0, 1'b0, 32'h0); cycle();
    flush = 1'b1;
    set_res(1'b0, 1'b0, 32'h0);
    cycle();

    // PC wrap-around on the sequential redirect, then an empty-queue resolve
    set_push(32'hFFFF_FFFE, 1'b1, 1'b1, 32'h1000); cycle();
    set_res(1'b0, 1'b0, 32'h0); cycle();
    set_res(1'b1, 1'b1, 32'h2000); cycle();

    // Taken branch with a wrong predicted target, then counter saturation
    set_push(32'h500, 1'b0, 1'b1, 32'h540); cycle();
    set_res(1'b1, 1'b1, 32'h580); cycle();
    for (int i = 0; i < 20; i++) begin
      set_push(32'h600 + 32'(8 * i), 1'b0, 1'b1, 32'h700); cycle();
      set_res(1'b0, 1'b0, 32'h0); cycle();
    end
    chk("mcnt_saturated", 32'(mispred_cnt), 32'hF);

    // Reset during a live pulse clears everything immediately
    set_push(32'hA00, 1'b0, 1'b1, 32'hB00); cycle();
    set_push(32'hA04, 1'b0, 1'b0, 32'h0); cycle();
    set_res(1'b0, 1'b0, 32'h0); cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_mispredict", 32'(mispredict), 32'd0);
    chk("midrst_ready", 32'(push_ready), 32'd1);
    chk("midrst_underflow", 32'(underflow), 32'd0);
    chk("midrst_mcnt", 32'(mispred_cnt), 32'd0);
    chk("midrst_bcnt", 32'(branch_cnt), 32'd0);
    mq.delete(); m_uf = 1'b0; m_bcnt = 0; m_mcnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_res(1'b0, 1'b0, 32'h0); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
